// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared types and constants for the sequential ripple-carry adder
package rca_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } rca_state_t;

endpackage : rca_pkg

// File: rtl/rca_nibble.sv
// rtl/rca_nibble.sv - combinational 4-bit ripple-carry adder slice
module rca_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    // Explicit bit-by-bit ripple so the carry chain is visible in the netlist.
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[4];
    end

endmodule : rca_nibble

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - W-bit adder built from one shared nibble adder, one nibble per cycle
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter  int NIB = 4,
    localparam int W   = NIB_W * NIB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int                IDX_W    = $clog2(NIB);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIB - 1);

    rca_state_t       state;
    rca_state_t       next_state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             load;
    logic             step;
    logic             last;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_cout;
    logic             ovf_next;

    assign nib_a = op_a[idx*NIB_W +: NIB_W];
    assign nib_b = op_b[idx*NIB_W +: NIB_W];
    assign last  = (idx == LAST_IDX);

    // Carry into the MSB is recovered from the top nibble's bit 3 sum.
    assign ovf_next = (nib_a[3] ^ nib_b[3] ^ nib_s[3]) ^ nib_cout;

    rca_nibble u_nibble (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_cout)
    );

    assign busy = (state == ST_ADD);
    assign done = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control; start during ADD is deliberately ignored.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_ADD;
                end
            end
            ST_ADD: begin
                step = 1'b1;
                if (last) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_ADD;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture, nibble-wise sum write-back and final flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
        end else if (step) begin
            sum[idx*NIB_W +: NIB_W] <= nib_s;
            carry                   <= nib_cout;
            if (last) begin
                idx  <= '0;
                cout <= nib_cout;
                ovf  <= ovf_next;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule : rca_seq_ctrl
